intc_irr_resolver: RTL

Interrupt request and priority resolution stage of the interrupt controller, directly upstream of the in-service register. It edge-detects the six interrupt lines (three fast, three normal) into an interrupt request register (IRR) and masks them against the interrupt mask and the current in-service bits. It then raises a request to the CPU and, on acknowledge, issues a one-cycle load pulse with a one-hot word. That word is OR-ed into the in-service register.

---
 rtl/intc_irr_resolver.sv | 119 +++++++++++
 1 files changed

// File: rtl/intc_irr_resolver.sv
// Interrupt request register with edge capture, priority resolution
// and the request/acknowledge handshake feeding the in-service register.
module intc_irr_resolver (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] irq,
  input  logic [5:0] imr,
  input  logic [5:0] isr_in,
  input  logic       inta,
  output logic       intr,
  output logic       isr_ld,
  output logic [5:0] isr_din,
  output logic [2:0] vec,
  output logic [5:0] irr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ACK
  } state_e;

  localparam logic [2:0] VecNone = 3'b111;

  state_e     state_q, state_d;
  logic [5:0] irq_q;
  logic [5:0] irr_q, irr_d;
  logic [2:0] vec_q, vec_d;
  logic [5:0] din_q, din_d;

  logic [5:0] rise;
  logic [5:0] elig;
  logic       any_elig;
  logic [2:0] sel;
  logic [5:0] sel_oh;
  logic [5:0] clr;
  logic       blk;

  assign rise = irq & ~irq_q;

  // An active in-service bit blocks its own level and everything below it.
  always_comb begin
    blk  = 1'b0;
    elig = '0;
    for (int i = 0; i < 6; i++) begin
      blk     = blk | isr_in[i];
      elig[i] = irr_q[i] & ~imr[i] & ~blk;
    end
  end

  always_comb begin
    sel = VecNone;
    for (int i = 5; i >= 0; i--) begin
      if (elig[i]) sel = 3'(i);
    end
  end

  assign any_elig = |elig;
  assign sel_oh   = any_elig ? (6'b000001 << sel) : 6'b000000;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    din_d   = din_q;
    clr     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (any_elig) state_d = S_REQ;
      end
      S_REQ: begin
        if (inta) begin
          state_d = S_ACK;
          if (any_elig) begin
            vec_d = sel;
            din_d = sel_oh;
            clr   = sel_oh;
          end else begin
            vec_d = VecNone;
            din_d = '0;
          end
        end else if (!any_elig) begin
          state_d = S_IDLE;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A fresh edge on the bit being granted stays pending.
  assign irr_d = (irr_q & ~clr) | rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      irq_q   <= '0;
      irr_q   <= '0;
      vec_q   <= VecNone;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq;
      irr_q   <= irr_d;
      vec_q   <= vec_d;
      din_q   <= din_d;
    end
  end

  assign intr    = (state_q == S_REQ);
  assign isr_ld  = (state_q == S_ACK) && (vec_q != VecNone);
  assign isr_din = (state_q == S_ACK) ? din_q : 6'b000000;
  assign vec     = vec_q;
  assign irr     = irr_q;

endmodule
